fir_tdf_param_sm: RTL

//  Parametrised transposed-direct-form FIR filter, sign-magnitude fixed point, one tap per coefficient.

---
 rtl/fir_tdf_param_sm_if.sv | 26 ++
 rtl/fir_tdf_param_sm.sv | 114 +++++++++++
 2 files changed

// File: rtl/fir_tdf_param_sm_if.sv
// Sample, coefficient-load and result signals of one FIR band path.
// The master drives samples and coefficient writes; the slave is the filter.
interface fir_tdf_param_sm_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] fir_in;
    logic              clr_state;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [DATA_W-1:0] coef_wdata;
    logic [DATA_W-1:0] fir_out;
    logic              out_valid;
    logic              sat_flag;

    modport master (
        output in_valid, fir_in, clr_state, coef_we, coef_addr, coef_wdata,
        input  fir_out, out_valid, sat_flag
    );

    modport slave (
        input  in_valid, fir_in, clr_state, coef_we, coef_addr, coef_wdata,
        output fir_out, out_valid, sat_flag
    );
endinterface

// File: rtl/fir_tdf_param_sm.sv
// Transposed-direct-form FIR, sign-magnitude samples/coefficients, two's complement
// partial sums with guard bits, saturating sign-magnitude output.

// One tap multiplier: sign-magnitude product returned as a sign-extended two's complement term.
module fir_tdf_param_sm_tap #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 21
) (
    input  logic [DATA_W-1:0] coef,
    input  logic [DATA_W-1:0] x,
    output logic [ACC_W-1:0]  prod
);
    logic [2*(DATA_W-1)-1:0] full;
    logic [DATA_W-2:0]       mag;
    logic [ACC_W-1:0]        ext;
    logic                    neg;

    always_comb begin
        full = coef[DATA_W-2:0] * x[DATA_W-2:0];
        mag  = (DATA_W-1)'(full >> (DATA_W-1));
        ext  = {{(ACC_W-DATA_W+1){1'b0}}, mag};
        // A zero magnitude always yields +0, which also absorbs -0 operands.
        neg  = (coef[DATA_W-1] ^ x[DATA_W-1]) && (mag != '0);
        prod = neg ? -ext : ext;
    end
endmodule

module fir_tdf_param_sm #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 30,
    parameter int GUARD  = 5,
    parameter int ADDR_W = 5
) (
    input logic               clk_slow,
    input logic               rst,
    fir_tdf_param_sm_if.slave bus
);
    localparam int ACC_W = DATA_W + GUARD;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(GUARD+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

    logic [TAPS-1:0][DATA_W-1:0] coef;
    logic [TAPS-1:0][ACC_W-1:0]  prod;
    logic [TAPS-2:0][ACC_W-1:0]  z;

    logic signed [ACC_W-1:0] acc;
    logic [DATA_W-1:0]       out_d;
    logic                    sat_d;
    logic [DATA_W-1:0]       fir_out_q;
    logic                    out_valid_q;
    logic                    sat_q;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        fir_tdf_param_sm_tap #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_tap (
            .coef (coef[k]),
            .x    (bus.fir_in),
            .prod (prod[k])
        );
    end

    assign acc = signed'(prod[0]) + signed'(z[0]);

    always_comb begin
        out_d = '0;
        sat_d = 1'b0;
        if (acc > SAT_MAX) begin
            out_d = {1'b0, {(DATA_W-1){1'b1}}};
            sat_d = 1'b1;
        end else if (acc < SAT_MIN) begin
            out_d = {1'b1, {(DATA_W-1){1'b1}}};
            sat_d = 1'b1;
        end else if (acc < 0) begin
            out_d = {1'b1, (DATA_W-1)'(-acc)};
        end else begin
            out_d = {1'b0, (DATA_W-1)'(acc)};
        end
    end

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            coef        <= '0;
            z           <= '0;
            fir_out_q   <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            // Out-of-range addresses match no tap and are dropped.
            for (int k = 0; k < TAPS; k++) begin
                if (bus.coef_we && bus.coef_addr == ADDR_W'(k))
                    coef[k] <= bus.coef_wdata;
            end

            if (bus.clr_state) begin
                z           <= '0;
                fir_out_q   <= '0;
                out_valid_q <= 1'b0;
                sat_q       <= 1'b0;
            end else if (bus.in_valid) begin
                for (int k = 0; k < TAPS-2; k++)
                    z[k] <= prod[k+1] + z[k+1];
                z[TAPS-2]   <= prod[TAPS-1];
                fir_out_q   <= out_d;
                out_valid_q <= 1'b1;
                sat_q       <= sat_d;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.fir_out   = fir_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sat_flag  = sat_q;
endmodule
